// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide sequencer for EX.
// Runs a registered one-pass multiply or a 32-step restoring divide.
// Divide-by-zero and signed overflow complete without iterating.
// Ports:
//   clk, reset          rising-edge clock, sync active-high reset
//   start               EX holds a valid M-op (held while stalled)
//   funct3              M-op select (MUL..REMU)
//   operand_a/_b        rs1 / rs2 values
//   flush               kill the in-flight or requested op
//   stall               hold IF/ID/EX (combinational)
//   busy                sequencer not idle
//   result_valid        one-cycle completion pulse (registered)
//   result              registered result, held until next completion
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [1:0]      op_kind;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] div_q;
    logic            neg_q;
    logic            neg_r;

    // ---- request decode (IDLE) ----
    logic            in_signed;
    logic            in_rem;
    logic            b_zero;
    logic            in_ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] special_res;

    always_comb begin
        in_signed = ~funct3[0];
        in_rem    = funct3[1];
        b_zero    = (operand_b == '0);
        in_ovf    = in_signed
                  & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                  & (&operand_b);
        a_abs     = (in_signed & operand_a[XLEN-1])
                  ? -operand_a : operand_a;
        b_abs     = (in_signed & operand_b[XLEN-1])
                  ? -operand_b : operand_b;
        special_res = '0;
        if (b_zero)
            special_res = in_rem ? operand_a : '1;
        else
            special_res = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---- multiply ----
    // Operands are sign/zero extended to full product width so a plain
    // unsigned multiply yields the correct low 2*XLEN bits of the
    // 33x33 signed/unsigned product.
    logic                a_sx;
    logic                b_sx;
    logic [2*XLEN-1:0]   a_ext;
    logic [2*XLEN-1:0]   b_ext;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     mul_res;

    always_comb begin
        a_sx    = ~(op_kind[1] & op_kind[0]);
        b_sx    = ~op_kind[1];
        a_ext   = {{XLEN{a_sx & op_a[XLEN-1]}}, op_a};
        b_ext   = {{XLEN{b_sx & op_b[XLEN-1]}}, op_b};
        prod    = a_ext * b_ext;
        mul_res = (op_kind == 2'b00)
                ? prod[XLEN-1:0]
                : prod[2*XLEN-1:XLEN];
    end

    // ---- restoring divide step ----
    // The shifted remainder is XLEN+1 bits wide; its top bit (rem_top)
    // set means it certainly exceeds the divisor, and the low XLEN bits
    // of the trial difference are then still the true remainder.
    logic            rem_top;
    logic [XLEN-1:0] rem_sh;
    logic [XLEN:0]   trial;
    logic            take;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] div_res;

    always_comb begin
        rem_top = rem_q[XLEN-1];
        rem_sh  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        trial   = {1'b0, rem_sh} - {1'b0, div_q};
        take    = rem_top | ~trial[XLEN];
        rem_nx  = take ? trial[XLEN-1:0] : rem_sh;
        quo_nx  = {quo_q[XLEN-2:0], take};
        q_fix   = neg_q ? -quo_nx : quo_nx;
        r_fix   = neg_r ? -rem_nx : rem_nx;
        div_res = op_kind[1] ? r_fix : q_fix;
    end

    // ---- control outputs ----
    always_comb begin
        stall = ((state == S_IDLE) & start & ~flush)
              | (state == S_MUL)
              | (state == S_DIV);
        busy  = (state != S_IDLE);
    end

    // ---- sequencer ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            counter      <= '0;
            op_kind      <= '0;
            op_a         <= '0;
            op_b         <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            div_q        <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_kind <= funct3[1:0];
                        op_a    <= operand_a;
                        op_b    <= operand_b;
                        neg_q   <= funct3[2] & in_signed
                                 & (operand_a[XLEN-1]
                                    ^ operand_b[XLEN-1]);
                        neg_r   <= funct3[2] & in_signed
                                 & operand_a[XLEN-1];
                        if (!funct3[2]) begin
                            state <= S_MUL;
                        end else if (b_zero || in_ovf) begin
                            result       <= special_res;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            counter <= CW'(XLEN - 1);
                            rem_q   <= '0;
                            quo_q   <= a_abs;
                            div_q   <= b_abs;
                            state   <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result       <= mul_res;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem_q   <= rem_nx;
                        quo_q   <= quo_nx;
                        counter <= counter - 1'b1;
                        if (counter == '0) begin
                            result       <= div_res;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                // The pipeline advances here; any start seen now
                // belongs to the next instruction.
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench for mdu_sequencer.
// Checks latency, stall/busy shape, results, abort and back-to-back.
module tb_mdu_sequencer;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at cycle 0 and follow it to its result pulse.
    task automatic run_op(input string tag,
                          input logic [2:0] f,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp,
                          input int lat);
        int vcyc;
        int bad;
        @(negedge clk);
        start = 1'b1;
        funct3 = f;
        operand_a = a;
        operand_b = b;
        #1;
        vcyc = -1;
        bad = 0;
        if (!stall || busy) bad++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (result_valid) begin
                vcyc = c;
                if (stall || !busy) bad++;
                check({tag, " result"}, result, exp);
                break;
            end else if (!stall || !busy) begin
                bad++;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(vcyc), 32'(lat));
        check({tag, " stall/busy shape"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, " single pulse"}, {31'd0, result_valid}, 32'd0);
        check({tag, " idle after"}, {31'd0, busy}, 32'd0);
    endtask

    // Kill a DIV -7/2 in its 10th DIV cycle by flush or reset.
    task automatic abort_op(input string tag,
                            input bit use_reset,
                            input logic [31:0] exp_res);
        int pulses;
        @(negedge clk);
        start = 1'b1;
        funct3 = F_DIV;
        operand_a = 32'hFFFF_FFF9;
        operand_b = 32'd2;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        start = 1'b0;
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        #1;
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " stall"}, {31'd0, stall}, 32'd0);
        check({tag, " valid"}, {31'd0, result_valid}, 32'd0);
        check({tag, " result kept"}, result, exp_res);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check({tag, " no pulse"}, 32'(pulses), 32'd0);
        check({tag, " result later"}, result, exp_res);
    endtask

    initial begin
        int pulses;
        int first;
        int second;
        int dbl;
        logic prev_rv;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        funct3 = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset valid", {31'd0, result_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        run_op("MUL 7*-3", F_MUL, 32'd7, 32'hFFFF_FFFD,
               32'hFFFF_FFEB, 2);
        run_op("MULH min*min", F_MULH, 32'h8000_0000,
               32'h8000_0000, 32'h4000_0000, 2);
        run_op("MULHU max*max", F_MULHU, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("MULHSU -1*max", F_MULHSU, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

        run_op("DIV 5/0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU 5/0", F_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("DIV ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1);
        run_op("REM ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 1);

        run_op("DIV -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFD, 33);
        run_op("REM -7/2", F_REM, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 33);
        run_op("DIVU 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 33);

        // flush beats start in IDLE
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        funct3 = F_MUL;
        operand_a = 32'd9;
        operand_b = 32'd9;
        #1;
        check("idle flush stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("idle flush busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("idle flush valid", {31'd0, result_valid}, 32'd0);
        check("idle flush result", result, 32'd2);

        abort_op("flush DIV", 1'b0, 32'd2);
        run_op("MUL 3*4 after flush", F_MUL, 32'd3, 32'd4,
               32'd12, 2);
        abort_op("reset DIV", 1'b1, 32'd0);
        run_op("MUL 3*4 after reset", F_MUL, 32'd3, 32'd4,
               32'd12, 2);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        funct3 = F_DIVU;
        operand_a = 32'd9;
        operand_b = 32'd3;
        pulses = 0;
        first = -1;
        second = -1;
        dbl = 0;
        prev_rv = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (first > 0 && c == first + 1) begin
                check("b2b accept idle", {31'd0, busy}, 32'd0);
                check("b2b accept stall", {31'd0, stall}, 32'd1);
            end
            if (result_valid) begin
                pulses++;
                if (prev_rv) dbl++;
                if (first < 0) begin
                    first = c;
                    check("b2b DIVU 9/3", result, 32'd3);
                    funct3 = F_MUL;
                    operand_a = 32'd2;
                    operand_b = 32'd5;
                end else if (second < 0) begin
                    second = c;
                    check("b2b MUL 2*5", result, 32'd10);
                    start = 1'b0;
                end
            end
            prev_rv = result_valid;
        end
        start = 1'b0;
        check("b2b first cycle", 32'(first), 32'd33);
        check("b2b second cycle", 32'(second), 32'd36);
        check("b2b pulse count", 32'(pulses), 32'd2);
        check("b2b no double", 32'(dbl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for the RV32M multiply/divide unit in the EX stage. It accepts one M-extension operation from the pipeline and runs it to completion: a registered single-pass multiply, or a 32-iteration restoring divide. While the operation is in flight it holds the pipeline with a stall, then delivers a one-cycle result pulse. It also handles the RISC-V divide-by-zero and signed-overflow cases without iterating.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX holds a valid M-op; held high by the pipeline while stalled.
- funct3  in  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  32  rs1 value (multiplicand / dividend).
- operand_b  in  32  rs2 value (multiplier / divisor).
- flush  in  1  kill the in-flight or requested op (branch/trap flush).
- stall  out  1  combinational; hold IF/ID/EX while high.
- busy  out  1  state != IDLE.
- result_valid  out  1  registered, one-cycle pulse with result.
- result  out  32  registered result; stable until the next completion.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start && !flush → capture funct3 and operands.
  - funct3[2]==0 → MUL.
  - Divide with operand_b==0 → DONE; result = 0xFFFFFFFF for DIV/DIVU, operand_a for REM/REMU.
  - Signed DIV/REM with a==0x80000000, b==0xFFFFFFFF → DONE; result = 0x80000000 for DIV, 0 for REM.
  - Any other divide → DIV; counter=31, remainder=0, quotient = |a| (signed) or a (unsigned), divisor = |b| or b.
  - Record neg_q = a[31]^b[31] and neg_r = a[31] for signed ops only.
- MUL (1 cycle):
  - 66-bit product of 33-bit extended operands: MUL/MULH sign×sign, MULHSU sign×zero, MULHU zero×zero.
  - Result = low 32 bits for MUL, bits [63:32] for the MULH variants.
  - Write result and go to DONE.
- DIV (32 cycles), each cycle:
  - {rem,quo} shifted left 1.
  - trial = rem_shifted − divisor (33-bit).
  - trial non-negative → rem = trial and quo LSB = 1; otherwise restore and quo LSB = 0.
  - counter decrements.
  - On the counter==0 cycle: apply sign correction (negate quotient if neg_q, remainder if neg_r), select quotient (DIV/DIVU) or remainder (REM/REMU), write result, go to DONE.
- DONE: result_valid=1, stall=0; next state IDLE unconditionally, even if start is high.
- stall = (IDLE && start && !flush) || MUL || DIV.
- flush:
  - In any state, next state is IDLE.
  - result_valid is not asserted for the killed op, and result is unchanged.
  - In IDLE, flush beats start and nothing is captured.
  - In DONE, the pulse still occurs because the op is already complete.
- reset: state=IDLE, counter=0, result=0, result_valid=0, internal registers 0. Reset mid-op aborts it the same way as flush.

## Timing
- Cycle 0 = the IDLE cycle with start accepted.
- Multiply: result_valid in cycle 2; stall high in cycles 0–1.
- Normal divide: DIV occupies cycles 1–32, result_valid in cycle 33; stall high in cycles 0–32.
- Divide-by-zero / overflow: result_valid in cycle 1; stall high in cycle 0 only.
- Back-to-back ops: a new start is accepted no earlier than the cycle after DONE. The pipeline advances in DONE, so start the next cycle belongs to the next instruction.
- result_valid is never high for two consecutive cycles.
- busy is low in exactly the cycles where the state is IDLE.

## Test plan
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB, result_valid in cycle 2, stall high in cycles 0–1 only.
- Multiply high variants:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each with result_valid in cycle 33.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - All with result_valid in cycle 1.
- Abort behaviour:
  - Flush asserted in DIV cycle 10 → no result_valid, IDLE next cycle, stall low, result unchanged.
  - A following MUL 3×4 → 12 in cycle 2.
  - Repeat with reset instead of flush → all outputs 0.
- Back-to-back: start held high across DIVU 9/3 then MUL 2×5 → results 3 then 10; second op accepted the cycle after the first DONE; exactly two result_valid pulses.
